// File: rtl/lc3_instr_packer.sv
// lc3_instr_packer: builds LC-3 instruction words from an opcode, register
// numbers and a full 16-bit value. The value is range-checked against the
// opcode's narrow field, truncated into it, and the word is queued in a
// 2-entry FIFO. range_err is stored with the word. A saturating counter
// tracks how many accepted requests were flagged.
module lc3_instr_packer #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [2:0]           reg_a,
    input  logic [2:0]           reg_b,
    input  logic [2:0]           reg_c,
    input  logic [2:0]           nzp,
    input  logic                 imm_mode,
    input  logic [15:0]          value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          instr,
    output logic                 range_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    opcode_e              w_op;
    logic [15:0]          w_instr;
    logic                 w_err;
    logic                 w_fit5;
    logic                 w_fit6;
    logic                 w_fit9;
    logic                 w_fit11;
    logic                 w_fit_trap;
    logic                 w_push;
    logic                 w_pop;
    logic [16:0]          w_head;

    logic [16:0]          r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_op = opcode_e'(opcode);

    // A value fits an N-bit signed field when all bits above the field's
    // sign bit equal that sign bit.
    assign w_fit5     = (value[15:4]  == '0) || (value[15:4]  == '1);
    assign w_fit6     = (value[15:5]  == '0) || (value[15:5]  == '1);
    assign w_fit9     = (value[15:8]  == '0) || (value[15:8]  == '1);
    assign w_fit11    = (value[15:10] == '0) || (value[15:10] == '1);
    assign w_fit_trap = (value[15:8]  == '0);

    // Combinational packing of the request into an instruction word plus error flag.
    always_comb begin
        w_instr        = '0;
        w_err          = 1'b0;
        w_instr[15:12] = opcode;
        case (w_op)
            OP_ADD, OP_AND: begin
                w_instr[11:9] = reg_a;
                w_instr[8:6]  = reg_b;
                if (imm_mode) begin
                    w_instr[5]   = 1'b1;
                    w_instr[4:0] = value[4:0];
                    w_err        = !w_fit5;
                end else begin
                    w_instr[2:0] = reg_c;
                end
            end
            OP_NOT: begin
                w_instr[11:9] = reg_a;
                w_instr[8:6]  = reg_b;
                w_instr[5:0]  = 6'b111111;
            end
            OP_BR: begin
                w_instr[11:9] = nzp;
                w_instr[8:0]  = value[8:0];
                w_err         = !w_fit9;
            end
            OP_LD, OP_LDI, OP_LEA, OP_ST, OP_STI: begin
                w_instr[11:9] = reg_a;
                w_instr[8:0]  = value[8:0];
                w_err         = !w_fit9;
            end
            OP_LDR, OP_STR: begin
                w_instr[11:9] = reg_a;
                w_instr[8:6]  = reg_b;
                w_instr[5:0]  = value[5:0];
                w_err         = !w_fit6;
            end
            OP_JSR: begin
                if (imm_mode) begin
                    w_instr[11]   = 1'b1;
                    w_instr[10:0] = value[10:0];
                    w_err         = !w_fit11;
                end else begin
                    w_instr[8:6]  = reg_b;
                end
            end
            OP_JMP: begin
                w_instr[8:6] = reg_b;
            end
            OP_TRAP: begin
                w_instr[7:0] = value[7:0];
                w_err        = !w_fit_trap;
            end
            OP_RTI: begin
                w_instr[11:0] = '0;
            end
            OP_RES: begin
                w_err = 1'b1;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Ready comes from registered occupancy only, so a full FIFO never
    // accepts even when a pop happens in the same cycle.
    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign instr     = out_valid ? w_head[16:1] : '0;
    assign range_err = out_valid ? w_head[0] : 1'b0;
    assign err_count = r_err_cnt;

    // FIFO storage; contents need no reset because outputs are masked by out_valid.
    always_ff @(posedge Clk) begin
        if (w_push && !Reset) begin
            r_mem[r_wr_ptr] <= {w_instr, w_err};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of accepted requests that were flagged.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lc3_instr_packer.sv
// Directed self-checking bench for lc3_instr_packer: packing per opcode,
// range boundaries, backpressure, streaming, reset and counter saturation.
module tb_lc3_instr_packer;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [2:0]  reg_a;
    logic [2:0]  reg_b;
    logic [2:0]  reg_c;
    logic [2:0]  nzp;
    logic        imm_mode;
    logic [15:0] value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr;
    logic        range_err;
    logic [7:0]  err_count;

    int unsigned total;
    int unsigned bad;
    int unsigned exp_errs;

    lc3_instr_packer #(.ERR_CNT_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .reg_c     (reg_c),
        .nzp       (nzp),
        .imm_mode  (imm_mode),
        .value     (value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .range_err (range_err),
        .err_count (err_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] n, input logic im,
                           input logic [15:0] v);
        opcode   = op;
        reg_a    = a;
        reg_b    = b;
        reg_c    = c;
        nzp      = n;
        imm_mode = im;
        value    = v;
    endtask

    // Single request into an empty FIFO with out_ready=1: visible next
    // cycle, then drained.
    task automatic one(input string tag, input logic [15:0] exp_instr, input logic exp_err);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (exp_err) exp_errs++;
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_err"}, {15'd0, range_err}, {15'd0, exp_err});
        chk({tag, "_cnt"}, {8'd0, err_count}, exp_errs[15:0]);
        step();
        chk({tag, "_drain"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_errs = 0;
        Reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_req(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        step();
        step();
        Reset = 1'b0;

        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_err", {15'd0, range_err}, 16'd0);
        chk("rst_cnt", {8'd0, err_count}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd1);

        // Packing and range boundaries.
        set_req(4'b0001, 3'd2, 3'd3, 3'd0, 3'd0, 1'b1, 16'hFFFB); one("add_imm", 16'h14FB, 1'b0);
        set_req(4'b0001, 3'd1, 3'd2, 3'd3, 3'd0, 1'b0, 16'hFFFF); one("add_reg", 16'h1283, 1'b0);
        set_req(4'b0101, 3'd1, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0010); one("and_imm_hi", 16'h52B0, 1'b1);
        set_req(4'b1001, 3'd2, 3'd3, 3'd0, 3'd0, 1'b0, 16'h1234); one("not", 16'h94FF, 1'b0);
        set_req(4'b0110, 3'd1, 3'd2, 3'd0, 3'd0, 1'b0, 16'h001F); one("ldr_max", 16'h629F, 1'b0);
        set_req(4'b0110, 3'd1, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0020); one("ldr_over", 16'h62A0, 1'b1);
        set_req(4'b0000, 3'd0, 3'd0, 3'd0, 3'd7, 1'b0, 16'hFF00); one("br_min", 16'h0F00, 1'b0);
        set_req(4'b0010, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFEFF); one("ld_under", 16'h26FF, 1'b1);
        set_req(4'b0100, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h03FF); one("jsr_max", 16'h4BFF, 1'b0);
        set_req(4'b0100, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0400); one("jsr_over", 16'h4C00, 1'b1);
        set_req(4'b0100, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0, 16'hFFFF); one("jsrr", 16'h4140, 1'b0);
        set_req(4'b1100, 3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0000); one("jmp", 16'hC1C0, 1'b0);
        set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0025); one("trap", 16'hF025, 1'b0);
        set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0125); one("trap_over", 16'hF025, 1'b1);
        set_req(4'b1101, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 16'hFFFF); one("reserved", 16'hD000, 1'b1);
        set_req(4'b1000, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 16'hFFFF); one("rti", 16'h8000, 1'b0);

        // Backpressure: two accepted, third held until a pop frees a slot.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0010);
        step();
        chk("bp_ready1", {15'd0, in_ready}, 16'd1);
        set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0011);
        step();
        chk("bp_ready2", {15'd0, in_ready}, 16'd0);
        set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0012);
        step();
        chk("bp_held_ready", {15'd0, in_ready}, 16'd0);
        chk("bp_head_a", instr, 16'hF010);
        out_ready = 1'b1;
        step();
        chk("bp_pop_ready", {15'd0, in_ready}, 16'd1);
        chk("bp_head_b", instr, 16'hF011);
        out_ready = 1'b0;
        step();
        chk("bp_c_in", {15'd0, in_ready}, 16'd0);
        chk("bp_hold_b", instr, 16'hF011);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_head_c", instr, 16'hF012);
        step();
        chk("bp_empty", {15'd0, out_valid}, 16'd0);

        // Streaming at one word per cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_req(4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0030 + 16'(i));
            step();
            chk("str_instr", instr, 16'hF030 + 16'(i));
            chk("str_ready", {15'd0, in_ready}, 16'd1);
        end
        in_valid = 1'b0;
        step();
        chk("str_empty", {15'd0, out_valid}, 16'd0);

        // Reset with a full FIFO and err_count=3.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        exp_errs = 0;
        set_req(4'b1101, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        one("res_a", 16'hD000, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        chk("full_cnt", {8'd0, err_count}, 16'd3);
        chk("full_ready", {15'd0, in_ready}, 16'd0);
        Reset = 1'b1;
        out_ready = 1'b1;
        step();
        Reset    = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", {15'd0, out_valid}, 16'd0);
        chk("mrst_instr", instr, 16'h0000);
        chk("mrst_err", {15'd0, range_err}, 16'd0);
        chk("mrst_cnt", {8'd0, err_count}, 16'd0);
        chk("mrst_ready", {15'd0, in_ready}, 16'd1);
        step();
        chk("mrst_nostale", {15'd0, out_valid}, 16'd0);

        // Counter saturation over 300 erroneous requests.
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) chk("sat_255", {8'd0, err_count}, 16'd255);
        end
        in_valid = 1'b0;
        step();
        chk("sat_300", {8'd0, err_count}, 16'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_instr_packer.md
Name: lc3_instr_packer

Overview:
- Inverse of the datapath sign-extension units: accepts an opcode, register numbers and a full 16-bit signed value, checks that the value fits the opcode's narrow immediate/offset field (imm5, offset6, PCoffset9, PCoffset11, trapvect8), truncates it into that field and emits a packed LC-3 instruction word.
- Used by the test-program loader and the debug path to build instruction words for memory.
- Valid/ready input, 2-entry output FIFO, saturating range-error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating range-error counter.

Ports:
- Clk  in  1  system clock; one clock domain.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  packer can accept a request this cycle.
- opcode  in  4  LC-3 opcode, placed in instr[15:12].
- reg_a  in  3  DR, or SR for ST/STI/STR, placed in [11:9].
- reg_b  in  3  SR1/BaseR, placed in [8:6].
- reg_c  in  3  SR2 for register-mode ADD/AND, placed in [2:0].
- nzp  in  3  branch condition bits for BR, placed in [11:9].
- imm_mode  in  1  ADD/AND: 1 = imm5; JSR: 1 = JSR, 0 = JSRR.
- value  in  16  signed immediate/offset; unsigned for TRAP.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head word.
- instr  out  16  packed instruction word at the FIFO head.
- range_err  out  1  head word had an out-of-range value or a reserved opcode.
- err_count  out  ERR_CNT_W  saturating count of accepted erroneous requests.

Behaviour:
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < 2). It depends only on registered state: no combinational path from out_ready, and no push-through when full, even if a pop occurs in the same cycle.
- Latency: a word accepted in cycle N is visible at instr/out_valid in cycle N+1 if the FIFO was empty. FIFO order is strict.
- Simultaneous push and pop with count == 1: count stays 1, the head advances to the new word.
- Packing is combinational on accept. Each entry stores {instr, range_err}. Unused bits are 0. Per opcode:
  - ADD 0001 / AND 0101:
    - imm_mode=1: [11:9]=reg_a, [8:6]=reg_b, [5]=1, [4:0]=value[4:0]; range is -16..15, i.e. value[15:4] all equal.
    - imm_mode=0: [5:3]=000, [2:0]=reg_c; no range check.
  - NOT 1001: [11:9]=reg_a, [8:6]=reg_b, [5:0]=111111.
  - BR 0000: [11:9]=nzp, [8:0]=value[8:0]; range -256..255.
  - LD 0010, LDI 1010, LEA 1110, ST 0011, STI 1011: [11:9]=reg_a, [8:0]=value[8:0]; range -256..255.
  - LDR 0110 / STR 0111: [11:9]=reg_a, [8:6]=reg_b, [5:0]=value[5:0]; range -32..31.
  - JSR 0100:
    - imm_mode=1: [11]=1, [10:0]=value[10:0]; range -1024..1023.
    - imm_mode=0 (JSRR): [11]=0, [8:6]=reg_b.
  - JMP 1100: [8:6]=reg_b.
  - TRAP 1111: [7:0]=value[7:0]; range 0..255, i.e. value[15:8]==0.
  - RTI 1000: all operand bits 0.
  - Reserved 1101: all operand bits 0, range_err=1.
- On a range error the field is still truncated and emitted; range_err flags the word, nothing is dropped.
- err_count increments by 1 per accepted request with an error and saturates at 2^ERR_CNT_W-1.
- Reset, including mid-operation, takes effect on the next edge:
  - FIFO emptied (count=0, pointers 0); in-flight words are discarded.
  - out_valid=0, instr=0x0000, range_err=0, err_count=0, in_ready=1 from the first cycle after reset.
  - A request presented in the reset cycle is not accepted.
- instr and range_err are 0 whenever out_valid=0.
- While out_valid=1 && out_ready=0, instr and range_err hold stable.

Test Plan:
- Reset, then ADD imm: opcode=0001, reg_a=2, reg_b=3, imm_mode=1, value=0xFFFB (-5) -> next cycle out_valid=1, instr=0x14FB, range_err=0.
- Range boundaries:
  - LDR value=0x001F -> instr[5:0]=011111, no error.
  - LDR value=0x0020 -> instr[5:0]=100000, range_err=1, err_count=1.
  - BR nzp=111, value=0xFF00 (-256) -> instr=0x0F00, no error.
- TRAP value=0x0025 -> instr=0xF025. TRAP value=0x0125 -> instr=0xF025, range_err=1. Opcode 1101 -> instr=0xD000, range_err=1.
- Backpressure: out_ready=0 with 3 back-to-back requests -> first two accepted, in_ready=0 on the third and held; raise out_ready for 1 cycle with in_valid=1 -> pop only, in_ready=1 next cycle; order preserved.
- Streaming: out_ready=1, one request every cycle -> one word out per cycle at 1-cycle latency, count never exceeds 1.
- Reset while FIFO holds 2 words and err_count=3 -> out_valid=0, instr=0, err_count=0, in_ready=1; no stale word emitted. Forcing 300 errors -> err_count stays at 255.
